midi_uart_rx: RTL and testbench
===============================

Name: midi_uart_rx

Overview:
Serial receiver for the MIDI DIN input. It deserialises 8N1 frames at 31250 baud from the opto-isolated RX pin. Each received byte is presented on data with a one-cycle dv strobe, which drives the data/dv inputs of the midi message parser directly downstream. Framing errors are flagged and the bad byte is discarded, so the parser only ever sees valid bytes.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD, 31250, serial bit rate in bits/s.
CLKS_PER_BIT, CLK_FREQ/BAUD (3200 at defaults), clock cycles per bit. Derived localparam; must be >= 4.
HALF_BIT, CLKS_PER_BIT/2 (floor), start-bit mid-point offset. Derived localparam.

Ports:
CLK  in  1  system clock; all logic on rising edge.
RST  in  1  reset; synchronous, active-low.
CE  in  1  clock enable; when low, all state, counters and synchroniser hold.
rx  in  1  asynchronous serial line; idles high.
data  out  8  last received byte, LSB first on the wire; held until the next valid byte.
dv  out  1  one-cycle pulse: data is valid and new.
ferr  out  1  one-cycle pulse: framing error, i.e. stop bit sampled low.

Behaviour:
- Reset (RST=0 at a CLK edge):
  - data=0, dv=0, ferr=0.
  - State=IDLE; bit counter and bit index = 0.
  - Both synchroniser flops = 1 (idle line).
  - Reset mid-frame aborts the frame; no dv or ferr results from it.
- Input conditioning:
  - rx passes through a 2-flop synchroniser giving rx_s. All decisions use rx_s.
  - Synchroniser latency is 2 cycles.
- CE=0:
  - No state, counter, shift-register or synchroniser update.
  - dv=0 and ferr=0 in every cycle with CE=0.
  - Timing resumes exactly where it stopped.
- State machine (every transition also requires CE=1):
  - IDLE: rx_s==0 -> START, cnt=0. Call this cycle s.
  - START: cnt counts to HALF_BIT-1, reached at cycle s+HALF_BIT. At that point rx_s is sampled:
    - sample 1 (glitch): -> IDLE, no output.
    - sample 0: -> DATA, cnt=0, idx=0.
  - DATA: cnt counts to CLKS_PER_BIT-1, then rx_s is sampled.
    - Samples are shifted in LSB first: shreg <= {rx_s, shreg[7:1]}.
    - idx increments after each sample. After the 8th sample -> STOP, cnt=0.
    - Bit i is sampled at cycle s+HALF_BIT+CLKS_PER_BIT*(i+1).
  - STOP: cnt counts to CLKS_PER_BIT-1, then rx_s is sampled. This is cycle s+HALF_BIT+9*CLKS_PER_BIT.
    - sample 1: data<=shreg, dv=1 for the next cycle only, -> IDLE.
    - sample 0: data unchanged, ferr=1 for the next cycle only, -> BREAK.
  - BREAK: wait for rx_s==1 -> IDLE. This prevents a held-low line or break from retriggering start.
- dv and ferr are registered and never high together. Both are 0 in every cycle not listed above.
- Back-to-back frames:
  - A start bit arriving immediately after the stop bit is detected from IDLE.
  - The half-bit resampling point absorbs up to +/-HALF_BIT-1 cycles of edge jitter per frame.
- Baud timing: no auto-baud. CLKS_PER_BIT integer truncation error is accepted; it is 0 at the defaults.
- data is never cleared except by reset.

Test Plan:
(all with CLK_FREQ=1000000, BAUD=31250, so CLKS_PER_BIT=32 and HALF_BIT=16)
1. Single byte: send 0x90 8N1 at 32 clk/bit -> exactly one dv pulse, at start-detect+305 cycles, with data=0x90; ferr stays 0.
2. Back-to-back: send 0x90, 0x45, 0x64 with no idle gap -> three dv pulses spaced 320 cycles apart carrying 0x90, 0x45, 0x64. When fed to the parser, its note number = 69 and velocity = 100.
3. Framing error:
   - send 0x55 with stop bit forced low, line then held low for 100 cycles, then high -> one ferr pulse, no dv, data keeps its previous value;
   - then send 0xC0 -> dv with data=0xC0.
4. Glitch rejection: drive an 8-cycle low pulse on an idle line -> FSM returns to IDLE at the start sample; no dv or ferr.
   - then send 0xFF -> dv with data=0xFF.
5. Reset mid-frame: assert RST=0 for 2 cycles during data bit 4 of 0x3C -> data=0, no dv or ferr;
   - then send 0x7F -> dv with data=0x7F.
6. CE hold: hold CE=0 for 50 cycles during bit 2 of 0xA5, with rx frozen for the same 50 cycles -> dv is delayed by exactly 50 cycles and data=0xA5; dv=0 while CE=0.

Source files
------------

// File: rtl/midi_uart_rx_if.sv
// midi_uart_rx_if: received-byte strobe bundle from the MIDI UART receiver to its consumer
interface midi_uart_rx_if;
  logic [7:0] data;
  logic       dv;
  logic       ferr;
  modport master (output data, dv, ferr);
  modport slave  (input  data, dv, ferr);
endinterface

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 MIDI serial receiver with mid-bit sampling and framing-error discard
module midi_uart_rx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 31250
) (
  input  logic CLK,
  input  logic RST,
  input  logic CE,
  input  logic rx,
  midi_uart_rx_if.master m
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n, data_q, data_n;
  logic [1:0] sync;
  logic dv_q, dv_n, ferr_q, ferr_n, rx_s, tick;
  assign rx_s   = sync[1];
  assign m.data = data_q;
  assign m.dv   = dv_q;
  assign m.ferr = ferr_q;
  assign tick   = cnt == (state == START ? CW'(HALF - 1) : CW'(CPB - 1));
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      data_q <= '0;
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;
      sync   <= 2'b11;
    end else if (CE) begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      shreg  <= shreg_n;
      data_q <= data_n;
      dv_q   <= dv_n;
      ferr_q <= ferr_n;
      sync   <= {sync[0], rx};
    end else begin
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data_q;
    dv_n    = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        state_n = rx_s ? IDLE : START;
      end
      START: if (tick) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_n   = '0;
        shreg_n = {rx_s, shreg[7:1]};
        idx_n   = idx + 1'b1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        cnt_n   = '0;
        data_n  = rx_s ? shreg : data_q;
        dv_n    = rx_s;
        ferr_n  = !rx_s;
        state_n = rx_s ? IDLE : BRK;
      end
      BRK: begin
        cnt_n   = '0;
        state_n = rx_s ? IDLE : BRK;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_midi_uart_rx.sv
// tb_midi_uart_rx: scoreboard bench driving 8N1 frames and checking byte, kind and arrival cycle of each strobe
module tb_midi_uart_rx;
  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 31250;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
  // two synchroniser flops plus the detect edge, then half a bit and nine full bits to the stop sample
  localparam int LAT      = 3 + HALF + 9 * CPB;
  typedef struct {bit fe; logic [7:0] d; int t;} ev_t;
  logic CLK = 0, RST = 0, CE = 1, rx = 1, ce_q = 1;
  int cyc = 0, n_chk = 0, n_fail = 0;
  ev_t q[$];
  ev_t e;
  midi_uart_rx_if ifc();
  midi_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (.CLK(CLK), .RST(RST), .CE(CE), .rx(rx), .m(ifc));
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    cyc  <= cyc + 1;
    ce_q <= CE;
  end
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge CLK) begin
    if (!ce_q) chk("dv_while_ce_low", int'(ifc.dv), 0);
    if (ifc.dv && ifc.ferr) chk("dv_and_ferr_together", 1, 0);
    else if (ifc.dv || ifc.ferr) begin
      if (q.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        e = q.pop_front();
        chk("pulse_kind_ferr", int'(ifc.ferr), int'(e.fe));
        chk("pulse_cycle", cyc, e.t);
        if (!e.fe) chk("rx_byte", int'(ifc.data), int'(e.d));
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop, input int hold_bit);
    ev_t x;
    rx = 0;
    x.fe = !stop;
    x.d = b;
    x.t = cyc + LAT + (hold_bit >= 0 ? 50 : 0);
    q.push_back(x);
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == hold_bit) begin
        idle(10);
        CE = 0;
        idle(50);
        CE = 1;
        idle(CPB - 10);
      end else idle(CPB);
    end
    rx = stop;
    idle(CPB);
  endtask
  initial begin
    logic [7:0] b;
    idle(3);
    chk("reset_data", int'(ifc.data), 0);
    chk("reset_dv", int'(ifc.dv), 0);
    chk("reset_ferr", int'(ifc.ferr), 0);
    RST = 1;
    idle(5);
    send_byte(8'h90, 1, -1);
    idle(40);
    send_byte(8'h90, 1, -1);
    send_byte(8'h45, 1, -1);
    send_byte(8'h64, 1, -1);
    idle(40);
    send_byte(8'h55, 0, -1);
    idle(100);
    rx = 1;
    idle(50);
    chk("data_kept_after_ferr", int'(ifc.data), 8'h64);
    send_byte(8'hC0, 1, -1);
    idle(40);
    rx = 0;
    idle(8);
    rx = 1;
    idle(100);
    send_byte(8'hFF, 1, -1);
    idle(40);
    b = 8'h3C;
    rx = 0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = b[4];
    idle(16);
    RST = 0;
    rx = 1;
    idle(2);
    RST = 1;
    idle(400);
    chk("data_after_midframe_reset", int'(ifc.data), 0);
    send_byte(8'h7F, 1, -1);
    idle(40);
    send_byte(8'hA5, 1, 2);
    idle(40);
    for (int k = 0; k < 20; k++) begin
      idle($urandom_range(0, 20));
      b = 8'($urandom);
      send_byte(b, 1, -1);
    end
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge CLK);
    chk("all_expected_pulses_seen", q.size(), 0);
    idle(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
